// File: rtl/wt_dcache_rd_miss_unit.sv
// ---------------------------------------------------------------------------
// wt_dcache_rd_miss_unit
//   Read-miss handler for a write-through dcache. Accepts one miss at a time
//   from the dcache controller and issues a single read to memory. When the
//   matching return arrives it hands the data back to the controller and, for
//   cacheable misses, refills the selected way.
//
// Ports
//   clk_i, rst_i         clock, async active-high reset
//   miss_*_i / miss_*_o  miss request handshake with the controller
//                        (ack = accepted, replay = rejected due to wbuffer hit)
//   miss_rtrn_vld_o      one-cycle pulse when a miss is served (rtrn_data_o)
//   mem_*_o / mem_ack_i  memory read request, held until acknowledged
//   mem_rtrn_*_i         memory return channel (only RdTxId is consumed)
//   wr_cl_*_o            cache line refill write port
// ---------------------------------------------------------------------------
module wt_dcache_rd_miss_unit #(
  parameter int SetAssoc = 4,
  parameter int PaddrW   = 34,
  parameter int ClIdxW   = 8,
  parameter int OffW     = 4,
  parameter int LineW    = 128,
  parameter int TidW     = 2,
  parameter int RdTxId   = 1,
  localparam int TagW    = PaddrW - ClIdxW - OffW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // miss request from the controller
  input  logic                miss_req_i,
  input  logic [PaddrW-1:0]   miss_paddr_i,
  input  logic                miss_nc_i,
  input  logic [2:0]          miss_size_i,
  input  logic [SetAssoc-1:0] miss_vld_bits_i,
  input  logic                wbuffer_hit_i,
  output logic                miss_ack_o,
  output logic                miss_replay_o,
  output logic                miss_rtrn_vld_o,
  output logic [LineW-1:0]    rtrn_data_o,
  // memory request
  output logic                mem_req_o,
  input  logic                mem_ack_i,
  output logic [PaddrW-1:0]   mem_paddr_o,
  output logic [2:0]          mem_size_o,
  output logic                mem_nc_o,
  output logic [TidW-1:0]     mem_tid_o,
  // memory return
  input  logic                mem_rtrn_vld_i,
  input  logic [TidW-1:0]     mem_rtrn_tid_i,
  input  logic [LineW-1:0]    mem_rtrn_data_i,
  // cache line refill
  output logic                wr_cl_vld_o,
  output logic [SetAssoc-1:0] wr_cl_we_o,
  output logic [TagW-1:0]     wr_cl_tag_o,
  output logic [ClIdxW-1:0]   wr_cl_idx_o,
  output logic [LineW-1:0]    wr_cl_data_o
);

  localparam int WayW = (SetAssoc > 1) ? $clog2(SetAssoc) : 1;

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT} state_e;

  typedef struct packed {
    logic [PaddrW-1:0]   paddr;
    logic                nc;
    logic [2:0]          size;
    logic [SetAssoc-1:0] way;   // one-hot refill way
  } miss_t;

  state_e      state_q, state_d;
  miss_t       miss_q, miss_d;
  logic [7:0]  lfsr_q, lfsr_d;

  logic                accept, replay, rtrn_hit, all_vld, found;
  logic [SetAssoc-1:0] way_oh;

  // Handshake terms. Gating with rst_i keeps all outputs low while reset is
  // held, even though ack/replay are combinational from the request.
  assign accept   = (state_q == IDLE) && miss_req_i && !wbuffer_hit_i && !rst_i;
  assign replay   = (state_q == IDLE) && miss_req_i &&  wbuffer_hit_i && !rst_i;
  assign rtrn_hit = (state_q == MEM_WAIT) && mem_rtrn_vld_i &&
                    (mem_rtrn_tid_i == TidW'(RdTxId));
  assign all_vld  = &miss_vld_bits_i;

  // Way select: first invalid way wins; when the set is full fall back to
  // the pseudo-random LFSR bits.
  always_comb begin
    way_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < SetAssoc; i++) begin
      if (!miss_vld_bits_i[i] && !found) begin
        way_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!found) way_oh[lfsr_q[WayW-1:0]] = 1'b1;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept)    state_d = MEM_REQ;
      MEM_REQ:  if (mem_ack_i) state_d = MEM_WAIT;
      MEM_WAIT: if (rtrn_hit)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_ack_o      = accept;
    miss_replay_o   = replay;
    miss_rtrn_vld_o = 1'b0;
    rtrn_data_o     = '0;
    mem_req_o       = 1'b0;
    mem_paddr_o     = '0;
    mem_size_o      = 3'b000;
    mem_nc_o        = 1'b0;
    mem_tid_o       = '0;
    wr_cl_vld_o     = 1'b0;
    wr_cl_we_o      = '0;
    wr_cl_tag_o     = '0;
    wr_cl_idx_o     = '0;
    wr_cl_data_o    = '0;
    unique case (state_q)
      MEM_REQ: begin
        mem_req_o = 1'b1;
        mem_nc_o  = miss_q.nc;
        mem_tid_o = TidW'(RdTxId);
        if (miss_q.nc) begin
          mem_paddr_o = miss_q.paddr;
          mem_size_o  = miss_q.size;
        end else begin
          // Cacheable misses always fetch the whole line, line-aligned.
          mem_paddr_o = {miss_q.paddr[PaddrW-1:OffW], {OffW{1'b0}}};
          mem_size_o  = 3'b111;
        end
      end
      MEM_WAIT: begin
        if (rtrn_hit) begin
          miss_rtrn_vld_o = 1'b1;
          rtrn_data_o     = mem_rtrn_data_i;
          if (!miss_q.nc) begin
            wr_cl_vld_o  = 1'b1;
            wr_cl_we_o   = miss_q.way;
            wr_cl_tag_o  = miss_q.paddr[PaddrW-1 -: TagW];
            wr_cl_idx_o  = miss_q.paddr[OffW +: ClIdxW];
            wr_cl_data_o = mem_rtrn_data_i;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    miss_d = miss_q;
    lfsr_d = lfsr_q;
    if (accept) begin
      miss_d.paddr = miss_paddr_i;
      miss_d.nc    = miss_nc_i;
      miss_d.size  = miss_size_i;
      miss_d.way   = way_oh;
      // Only consume a random value when it actually picked a victim.
      if (!miss_nc_i && all_vld)
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_q <= '0;
      lfsr_q <= 8'hA5;
    end else begin
      miss_q <= miss_d;
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_miss_unit.sv
module tb_wt_dcache_rd_miss_unit;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         miss_req_i;
  logic [33:0]  miss_paddr_i;
  logic         miss_nc_i;
  logic [2:0]   miss_size_i;
  logic [3:0]   miss_vld_bits_i;
  logic         wbuffer_hit_i;
  logic         miss_ack_o, miss_replay_o, miss_rtrn_vld_o;
  logic [127:0] rtrn_data_o;
  logic         mem_req_o, mem_ack_i;
  logic [33:0]  mem_paddr_o;
  logic [2:0]   mem_size_o;
  logic         mem_nc_o;
  logic [1:0]   mem_tid_o;
  logic         mem_rtrn_vld_i;
  logic [1:0]   mem_rtrn_tid_i;
  logic [127:0] mem_rtrn_data_i;
  logic         wr_cl_vld_o;
  logic [3:0]   wr_cl_we_o;
  logic [21:0]  wr_cl_tag_o;
  logic [7:0]   wr_cl_idx_o;
  logic [127:0] wr_cl_data_o;

  wt_dcache_rd_miss_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_req_i(miss_req_i), .miss_paddr_i(miss_paddr_i), .miss_nc_i(miss_nc_i),
    .miss_size_i(miss_size_i), .miss_vld_bits_i(miss_vld_bits_i),
    .wbuffer_hit_i(wbuffer_hit_i), .miss_ack_o(miss_ack_o),
    .miss_replay_o(miss_replay_o), .miss_rtrn_vld_o(miss_rtrn_vld_o),
    .rtrn_data_o(rtrn_data_o), .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
    .mem_paddr_o(mem_paddr_o), .mem_size_o(mem_size_o), .mem_nc_o(mem_nc_o),
    .mem_tid_o(mem_tid_o), .mem_rtrn_vld_i(mem_rtrn_vld_i),
    .mem_rtrn_tid_i(mem_rtrn_tid_i), .mem_rtrn_data_i(mem_rtrn_data_i),
    .wr_cl_vld_o(wr_cl_vld_o), .wr_cl_we_o(wr_cl_we_o),
    .wr_cl_tag_o(wr_cl_tag_o), .wr_cl_idx_o(wr_cl_idx_o),
    .wr_cl_data_o(wr_cl_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] m_lfsr;   // reference LFSR state

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // x^8+x^6+x^5+x^4+1 : shift left, new bit = parity of taps 8,6,5,4
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  function automatic logic [3:0] exp_way(input logic [3:0] vld, input logic [7:0] l);
    for (int i = 0; i < 4; i++)
      if (!vld[i]) return 4'(1 << i);
    return 4'(1 << l[1:0]);
  endfunction

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one miss end-to-end. Called right after a rising edge.
  task automatic miss_txn(input logic [33:0] pa, input logic nc, input logic [2:0] sz,
                          input logic [3:0] vld, input logic whit,
                          input int ack_dly, input int rtn_dly, input logic stray);
    logic [3:0]   ew;
    logic [33:0]  ep;
    logic [2:0]   es;
    logic [127:0] d;
    miss_req_i = 1'b1; miss_paddr_i = pa; miss_nc_i = nc; miss_size_i = sz;
    miss_vld_bits_i = vld; wbuffer_hit_i = whit;
    @(negedge clk_i);
    if (whit) begin
      chk("replay", miss_replay_o, 1);
      chk("ack_on_hit", miss_ack_o, 0);
      @(posedge clk_i); #1 miss_req_i = 1'b0; wbuffer_hit_i = 1'b0;
      @(negedge clk_i);
      chk("memreq_after_replay", mem_req_o, 0);
      @(posedge clk_i); #1;
      return;
    end
    chk("ack", miss_ack_o, 1);
    chk("replay_with_ack", miss_replay_o, 0);
    ew = exp_way(vld, m_lfsr);
    if (!nc && vld == 4'hF) m_lfsr = lfsr_next(m_lfsr);
    ep = nc ? pa : (pa & ~34'hF);
    es = nc ? sz : 3'b111;
    @(posedge clk_i); #1 miss_req_i = 1'b0;
    for (int k = 0; k <= ack_dly; k++) begin
      @(negedge clk_i);
      chk("mem_req", mem_req_o, 1);
      chk("mem_paddr", mem_paddr_o, ep);
      chk("mem_size", mem_size_o, es);
      chk("mem_nc", mem_nc_o, nc);
      chk("mem_tid", mem_tid_o, 1);
      if (k == ack_dly) mem_ack_i = 1'b1;
      @(posedge clk_i); #1 mem_ack_i = 1'b0;
    end
    if (stray) begin
      mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd2; mem_rtrn_data_i = rnd_line();
      @(negedge clk_i);
      chk("stray_rtrn", miss_rtrn_vld_o, 0);
      chk("stray_wr", wr_cl_vld_o, 0);
      @(posedge clk_i); #1 mem_rtrn_vld_i = 1'b0;
    end
    for (int k = 0; k < rtn_dly; k++) begin
      @(negedge clk_i);
      chk("wait_memreq", mem_req_o, 0);
      chk("wait_rtrn", miss_rtrn_vld_o, 0);
      @(posedge clk_i); #1;
    end
    // Return cycle, with a competing new request that must not be accepted.
    d = rnd_line();
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd1; mem_rtrn_data_i = d;
    miss_req_i = 1'b1; wbuffer_hit_i = 1'b0; miss_paddr_i = {$urandom, 2'b00};
    @(negedge clk_i);
    chk("rtrn_vld", miss_rtrn_vld_o, 1);
    chk("rtrn_data", rtrn_data_o, d);
    chk("ack_in_rtrn", miss_ack_o, 0);
    chk("wr_vld", wr_cl_vld_o, !nc);
    chk("wr_we", wr_cl_we_o, nc ? 4'b0 : ew);
    if (!nc) begin
      chk("wr_tag", wr_cl_tag_o, pa[33:12]);
      chk("wr_idx", wr_cl_idx_o, pa[11:4]);
      chk("wr_data", wr_cl_data_o, d);
    end
    @(posedge clk_i); #1 mem_rtrn_vld_i = 1'b0; miss_req_i = 1'b0;
    @(negedge clk_i);
    chk("rtrn_pulse", miss_rtrn_vld_o, 0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b1; miss_req_i = 0; miss_paddr_i = '0; miss_nc_i = 0; miss_size_i = '0;
    miss_vld_bits_i = '0; wbuffer_hit_i = 0; mem_ack_i = 0; mem_rtrn_vld_i = 0;
    mem_rtrn_tid_i = '0; mem_rtrn_data_i = '0;
    m_lfsr = 8'hA5;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_memreq", mem_req_o, 0);
    chk("rst_paddr", mem_paddr_o, 0);
    chk("rst_ack", miss_ack_o, 0);
    chk("rst_rtrn", miss_rtrn_vld_o, 0);
    chk("rst_wr", wr_cl_vld_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Full sets right after reset: LFSR seed, then its successor; stray tid.
    miss_txn(34'h0_0000_1230, 0, 3'b111, 4'hF, 0, 0, 1, 1);
    miss_txn(34'h0_0000_4560, 0, 3'b111, 4'hF, 0, 1, 0, 1);
    // Reference cacheable miss (ack in cycle 3, return in cycle 6).
    miss_txn(34'h0_1234_5678, 0, 3'b011, 4'b1011, 0, 2, 2, 0);
    // Non-cacheable word access.
    miss_txn(34'h1000_0004, 1, 3'b010, 4'b0000, 0, 0, 3, 0);
    // Write buffer conflict, then retry.
    miss_txn(34'h0_0ABC_DEF0, 0, 3'b111, 4'b0001, 1, 0, 0, 0);
    miss_txn(34'h0_0ABC_DEF0, 0, 3'b111, 4'b0001, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [33:0] pa;
      logic        nc;
      logic [3:0]  vld;
      pa  = {$urandom_range(3, 0), $urandom};
      nc  = ($urandom_range(3, 0) == 0);
      vld = ($urandom_range(1, 0) == 0) ? 4'hF : 4'($urandom);
      miss_txn(pa, nc, 3'($urandom_range(3, 0)), vld, ($urandom_range(4, 0) == 0),
               $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom));
    end

    // Reset while waiting for a return; the late return must be dropped.
    miss_req_i = 1'b1; miss_paddr_i = 34'h0_0000_7770; miss_nc_i = 0;
    miss_vld_bits_i = 4'hF; wbuffer_hit_i = 0;
    @(negedge clk_i);
    chk("abort_ack", miss_ack_o, 1);
    @(posedge clk_i); #1 miss_req_i = 1'b0; mem_ack_i = 1'b1;
    @(posedge clk_i); #1 mem_ack_i = 1'b0;
    rst_i = 1'b1;
    m_lfsr = 8'hA5;
    @(negedge clk_i);
    chk("abort_rst_memreq", mem_req_o, 0);
    chk("abort_rst_rtrn", miss_rtrn_vld_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd1; mem_rtrn_data_i = rnd_line();
    @(negedge clk_i);
    chk("abort_late_rtrn", miss_rtrn_vld_o, 0);
    chk("abort_late_wr", wr_cl_vld_o, 0);
    chk("abort_idle_memreq", mem_req_o, 0);
    @(posedge clk_i); #1 mem_rtrn_vld_i = 1'b0;
    // Back in IDLE with the LFSR re-seeded.
    miss_txn(34'h0_0000_8880, 0, 3'b111, 4'hF, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
